jesd204_tx_cmd_scheduler: RTL and testbench

- Sequences the JESD204C TX command channel: arbitrates 19-bit command words from NUM_REQ requesters and drives the cmd field consumed by the TX sync-header generator once per multiblock (lmc_edge).
- Fragments commands to fit the per-multiblock capacity of the active header mode: 19 bits in stand-alone mode, 7 bits in CRC-12/CRC-3 modes, 0 bits in FEC mode.
- Sits between link-layer command sources and the header generator, in the link clock domain.

---
 rtl/jesd204_tx_cmd_scheduler_if.sv | 32 +++
 rtl/jesd204_tx_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_jesd204_tx_cmd_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/jesd204_tx_cmd_scheduler_if.sv
// -----------------------------------------------------------------------------
// jesd204_tx_cmd_scheduler_if
// Groups the requester handshake and the header-generator command field of the
// JESD204C TX command scheduler.
//   req_valid/req_data/req_ready : NUM_REQ requesters, 19-bit words, valid/ready
//   cmd/cmd_valid/cmd_frag/cmd_last : fragment driven to the sync-header generator
//   status_owner/status_count    : in-flight owner (one-hot), completed count
// Modports: master = scheduler side, slave = requesters / header generator side.
// -----------------------------------------------------------------------------
interface jesd204_tx_cmd_scheduler_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*19-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [18:0]           cmd;
   logic                  cmd_valid;
   logic [1:0]            cmd_frag;
   logic                  cmd_last;
   logic [NUM_REQ-1:0]    status_owner;
   logic [15:0]           status_count;

   modport master (
      input  req_valid, req_data,
      output req_ready, cmd, cmd_valid, cmd_frag, cmd_last, status_owner, status_count
   );

   modport slave (
      output req_valid, req_data,
      input  req_ready, cmd, cmd_valid, cmd_frag, cmd_last, status_owner, status_count
   );
endinterface

// File: rtl/jesd204_tx_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// jesd204_tx_cmd_scheduler
// Arbitrates 19-bit command words from NUM_REQ requesters and fragments them
// into the per-multiblock command field of the JESD204C TX sync header.
// Capacity per multiblock: 19 bits (mode 11), 7 bits (modes 00/01), 0 (mode 10).
// State only advances on clk edges with lmc_edge=1; the fragment registered at
// boundary k is transmitted by the header generator at boundary k+1.
// Ports:
//   clk, resetn          : link clock, asynchronous active-low reset
//   cfg_enable           : enable; low flushes the in-flight command
//   cfg_header_mode      : 00 CRC-12, 01 CRC-3, 10 FEC, 11 stand-alone command
//   lmc_edge             : multiblock boundary strobe
//   bus (master modport) : requester handshake, cmd field and status
// Build option: JESD204_TX_CMD_PRIORITY_EN selects fixed priority (lowest index
// wins) instead of round-robin; the round-robin pointer is then not built.
// -----------------------------------------------------------------------------
module jesd204_tx_cmd_scheduler #(
   parameter int          NUM_REQ  = 2,
   parameter logic [18:0] IDLE_CMD = 19'h00000
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               cfg_enable,
   input  logic [1:0]                         cfg_header_mode,
   input  logic                               lmc_edge,
   jesd204_tx_cmd_scheduler_if.master         bus
);
   localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] MODE_CRC12 = 2'b00;
   localparam logic [1:0] MODE_CRC3  = 2'b01;
   localparam logic [1:0] MODE_FEC   = 2'b10;
   localparam logic [1:0] MODE_CMD   = 2'b11;

   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

   state_t             state_r;
   logic [1:0]         frag_r;
   logic [18:0]        data_r;
   logic [18:0]        cmd_r;
   logic               cmd_valid_r;
   logic               cmd_last_r;
   logic [NUM_REQ-1:0] owner_r;
   logic [15:0]        count_r;

   logic [NUM_REQ-1:0] grant_s;
   logic               grant_any_s;
   logic [18:0]        grant_data_s;
   logic               grant_en_s;
   logic [18:0]        idle_cmd_s;
   int                 idx_s;
`ifndef JESD204_TX_CMD_PRIORITY_EN
   logic [PTR_W-1:0]   ptr_r;
   logic [PTR_W-1:0]   grant_idx_s;
   logic [PTR_W-1:0]   ptr_nxt_s;
   int                 ptr_sum_s;
`endif

   // Slice a captured command into the fragment carried in one multiblock.
   function automatic logic [18:0] frag_word(input logic [1:0] mode,
                                             input logic [1:0] frag,
                                             input logic [18:0] data);
      logic [18:0] w;
      w = 19'h00000;
      case (mode)
         MODE_CMD: w = data;
         MODE_CRC12, MODE_CRC3: begin
            case (frag)
               2'd0:    w = {12'h000, data[6:0]};
               2'd1:    w = {12'h000, data[13:7]};
               2'd2:    w = {14'h0000, data[18:14]};
               default: w = 19'h00000;
            endcase
         end
         default: w = 19'h00000;
      endcase
      return w;
   endfunction

   // Requester search: first valid requester starting at the pointer (or index 0).
   always_comb begin
      grant_s      = {NUM_REQ{1'b0}};
      grant_any_s  = 1'b0;
      grant_data_s = 19'h00000;
      idx_s        = 0;
`ifndef JESD204_TX_CMD_PRIORITY_EN
      grant_idx_s  = {PTR_W{1'b0}};
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef JESD204_TX_CMD_PRIORITY_EN
         idx_s = k;
`else
         idx_s = (int'(ptr_r) + k) % NUM_REQ;
`endif
         if (!grant_any_s && bus.req_valid[idx_s]) begin
            grant_any_s         = 1'b1;
            grant_s[idx_s]      = 1'b1;
            grant_data_s        = bus.req_data[19*idx_s +: 19];
`ifndef JESD204_TX_CMD_PRIORITY_EN
            grant_idx_s         = idx_s[PTR_W-1:0];
`endif
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

`ifndef JESD204_TX_CMD_PRIORITY_EN
   // Pointer moves just past the granted requester, wrapping modulo NUM_REQ.
   always_comb begin
      ptr_sum_s = (int'(grant_idx_s) + 1) % NUM_REQ;
      ptr_nxt_s = ptr_sum_s[PTR_W-1:0];
   end
`endif

   // A grant needs a boundary, an enabled non-FEC link and a free command slot.
   assign grant_en_s = lmc_edge & cfg_enable & (cfg_header_mode != MODE_FEC) &
                       ((state_r == ST_IDLE) | cmd_last_r) & grant_any_s;

   // Idle value follows the mode's field width; the mode is static while enabled.
   always_comb begin
      idle_cmd_s = 19'h00000;
      case (cfg_header_mode)
         MODE_FEC: idle_cmd_s = 19'h00000;
         MODE_CMD: idle_cmd_s = IDLE_CMD;
         default:  idle_cmd_s = {12'h000, IDLE_CMD[6:0]};
      endcase
   end

   // Scheduler FSM: grant, fragment advance, completion count and flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         frag_r      <= 2'd0;
         data_r      <= 19'h00000;
         cmd_r       <= 19'h00000;
         cmd_valid_r <= 1'b0;
         cmd_last_r  <= 1'b0;
         owner_r     <= {NUM_REQ{1'b0}};
         count_r     <= 16'h0000;
`ifndef JESD204_TX_CMD_PRIORITY_EN
         ptr_r       <= {PTR_W{1'b0}};
`endif
      end else if (!cfg_enable) begin
         // Flush drops the in-flight command uncounted; pointer/count survive.
         state_r     <= ST_IDLE;
         frag_r      <= 2'd0;
         cmd_r       <= 19'h00000;
         cmd_valid_r <= 1'b0;
         cmd_last_r  <= 1'b0;
         owner_r     <= {NUM_REQ{1'b0}};
      end else if (lmc_edge) begin
         // The last fragment was sent on this boundary: the command is complete.
         if ((state_r == ST_SEND) && cmd_last_r && (cfg_header_mode != MODE_FEC)) begin
            count_r <= count_r + {15'h0000, (count_r != 16'hFFFF)};
         end
         if (grant_en_s) begin
            state_r     <= ST_SEND;
            frag_r      <= 2'd0;
            data_r      <= grant_data_s;
            owner_r     <= grant_s;
            cmd_r       <= frag_word(cfg_header_mode, 2'd0, grant_data_s);
            cmd_valid_r <= 1'b1;
            cmd_last_r  <= (cfg_header_mode == MODE_CMD);
`ifndef JESD204_TX_CMD_PRIORITY_EN
            ptr_r       <= ptr_nxt_s;
`endif
         end else if ((state_r == ST_SEND) && !cmd_last_r && (cfg_header_mode != MODE_FEC)) begin
            frag_r      <= frag_r + 2'd1;
            cmd_r       <= frag_word(cfg_header_mode, frag_r + 2'd1, data_r);
            cmd_last_r  <= (frag_r == 2'd1);
         end else begin
            state_r     <= ST_IDLE;
            frag_r      <= 2'd0;
            cmd_r       <= 19'h00000;
            cmd_valid_r <= 1'b0;
            cmd_last_r  <= 1'b0;
            owner_r     <= {NUM_REQ{1'b0}};
         end
      end
   end

   assign bus.req_ready    = grant_en_s ? grant_s : {NUM_REQ{1'b0}};
   assign bus.cmd          = cmd_valid_r ? cmd_r : idle_cmd_s;
   assign bus.cmd_valid    = cmd_valid_r;
   assign bus.cmd_frag     = frag_r;
   assign bus.cmd_last     = cmd_last_r;
   assign bus.status_owner = owner_r;
   assign bus.status_count = count_r;
endmodule

// File: tb/tb_jesd204_tx_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jesd204_tx_cmd_scheduler
// Directed bench: expected fragments are queued when a request is driven and
// popped after each multiblock boundary. Expectations for the arbitration test
// follow JESD204_TX_CMD_PRIORITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_jesd204_tx_cmd_scheduler;
   localparam int NR = 2;

   typedef struct {
      logic [18:0]   cmd;
      logic [1:0]    frag;
      logic          last;
      logic [NR-1:0] owner;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       cfg_enable;
   logic [1:0] mode;
   logic       lmc_edge;
   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   jesd204_tx_cmd_scheduler_if #(.NUM_REQ(NR)) bus();

   jesd204_tx_cmd_scheduler #(.NUM_REQ(NR), .IDLE_CMD(19'h00000)) u_dut (
      .clk             (clk),
      .resetn          (resetn),
      .cfg_enable      (cfg_enable),
      .cfg_header_mode (mode),
      .lmc_edge        (lmc_edge),
      .bus             (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of fragmentation: queue the fragments a granted command will produce.
   task automatic push_cmd(input logic [1:0] m, input logic [18:0] d, input logic [NR-1:0] own);
      if (m == 2'b11) begin
         exp_q.push_back('{d, 2'd0, 1'b1, own});
      end else if (m == 2'b00 || m == 2'b01) begin
         exp_q.push_back('{{12'h000, d[6:0]},   2'd0, 1'b0, own});
         exp_q.push_back('{{12'h000, d[13:7]},  2'd1, 1'b0, own});
         exp_q.push_back('{{14'h0000, d[18:14]}, 2'd2, 1'b1, own});
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      logic vld;
      vld = (exp_q.size() > 0);
      if (vld) e = exp_q.pop_front();
      else     e = '{19'h00000, 2'd0, 1'b0, {NR{1'b0}}};
      check({tag, "_cmd"},   {13'h0, bus.cmd},          {13'h0, e.cmd});
      check({tag, "_valid"}, {31'h0, bus.cmd_valid},    {31'h0, vld});
      check({tag, "_frag"},  {30'h0, bus.cmd_frag},     {30'h0, e.frag});
      check({tag, "_last"},  {31'h0, bus.cmd_last},     {31'h0, e.last});
      check({tag, "_owner"}, {30'h0, bus.status_owner}, {30'h0, e.owner});
   endtask

   // One multiblock: strobe lmc_edge for one cycle, checking req_ready mid-cycle.
   task automatic mb(input logic [NR-1:0] exp_ready, input string tag);
      repeat (2) @(posedge clk);
      #1 lmc_edge = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, {30'h0, bus.req_ready}, {30'h0, exp_ready});
      @(posedge clk);
      #1 lmc_edge = 1'b0;
   endtask

   task automatic set_mode(input logic [1:0] m);
      cfg_enable = 1'b0;
      @(posedge clk);
      #1 mode = m;
      cfg_enable = 1'b1;
   endtask

   initial begin
      logic [NR-1:0] g;
      logic [18:0]   d0, d1;
      resetn = 1'b0; cfg_enable = 1'b0; mode = 2'b11; lmc_edge = 1'b0;
      bus.req_valid = '0; bus.req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset");
      check("reset_ready", {30'h0, bus.req_ready}, 32'h0);
      check("reset_count", {16'h0, bus.status_count}, 32'h0);
      resetn = 1'b1;
      @(posedge clk);
      #1 cfg_enable = 1'b1;

      // Stand-alone mode, single 19-bit fragment.
      d0 = 19'h5A5A5;
      bus.req_data[18:0] = d0; bus.req_valid = 2'b01;
      push_cmd(2'b11, d0, 2'b01);
      mb(2'b01, "m11_e1"); bus.req_valid = 2'b00;
      check_out("m11_e1");
      check("m11_cnt0", {16'h0, bus.status_count}, 32'd0);
      mb(2'b00, "m11_e2");
      check_out("m11_e2");
      check("m11_cnt1", {16'h0, bus.status_count}, 32'd1);

      // CRC-3 mode, three 7-bit fragments from requester 1.
      set_mode(2'b01);
      d1 = 19'h7FFFF;
      bus.req_data[37:19] = d1; bus.req_valid = 2'b10;
      push_cmd(2'b01, d1, 2'b10);
      mb(2'b10, "m01_e1"); bus.req_valid = 2'b00;
      check_out("m01_f0");
      mb(2'b00, "m01_e2"); check_out("m01_f1");
      mb(2'b00, "m01_e3"); check_out("m01_f2");
      mb(2'b00, "m01_e4"); check_out("m01_idle");
      check("m01_cnt", {16'h0, bus.status_count}, 32'd2);

      // Two requesters continuously valid, back-to-back grants.
      set_mode(2'b11);
      d0 = 19'h11111; d1 = 19'h22222;
      bus.req_data = {d1, d0}; bus.req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
`ifdef JESD204_TX_CMD_PRIORITY_EN
         g = 2'b01;
`else
         g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
         push_cmd(2'b11, (g == 2'b01) ? d0 : d1, g);
         mb(g, "arb_e");
         check_out("arb");
         check("arb_cnt", {16'h0, bus.status_count}, 32'(2 + n));
      end
      bus.req_valid = 2'b00;
      mb(2'b00, "arb_end"); check_out("arb_end");
      check("arb_cnt_end", {16'h0, bus.status_count}, 32'd6);

      // CRC-12 mode, flush after fragment 1.
      set_mode(2'b00);
      d0 = 19'h12345;
      bus.req_data[18:0] = d0; bus.req_valid = 2'b01;
      push_cmd(2'b00, d0, 2'b01);
      mb(2'b01, "fl_e1"); bus.req_valid = 2'b00;
      check_out("fl_f0");
      mb(2'b00, "fl_e2"); check_out("fl_f1");
      cfg_enable = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      check_out("fl_flush");
      check("fl_cnt", {16'h0, bus.status_count}, 32'd6);
      bus.req_valid = 2'b01;
      mb(2'b00, "fl_dis");
      check_out("fl_dis");
      cfg_enable = 1'b1;
      @(posedge clk); #1;
      check_out("fl_reen");
      push_cmd(2'b00, d0, 2'b01);
      mb(2'b01, "fl_g"); bus.req_valid = 2'b00;
      check_out("fl_g0");
      mb(2'b00, "fl_g1"); check_out("fl_g1");
      mb(2'b00, "fl_g2"); check_out("fl_g2");
      mb(2'b00, "fl_g3"); check_out("fl_g3");
      check("fl_cnt2", {16'h0, bus.status_count}, 32'd7);

      // FEC mode: no capacity, nothing granted.
      set_mode(2'b10);
      bus.req_valid = 2'b01;
      for (int n = 0; n < 8; n++) begin
         mb(2'b00, "fec");
         check_out("fec");
      end
      bus.req_valid = 2'b00;
      check("fec_cnt", {16'h0, bus.status_count}, 32'd7);

      // Asynchronous reset in the middle of a multi-fragment command.
      set_mode(2'b01);
      d1 = 19'h7FFFF;
      bus.req_data[37:19] = d1; bus.req_valid = 2'b10;
      push_cmd(2'b01, d1, 2'b10);
      mb(2'b10, "rst_e1"); bus.req_valid = 2'b00;
      check_out("rst_f0");
      @(negedge clk);
      resetn = 1'b0;
      #1;
      exp_q.delete();
      check_out("rst_async");
      check("rst_cnt", {16'h0, bus.status_count}, 32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
